// File: rtl/vend_pkg.sv
// Shared types and constants for the change-hopper arbiter: FSM state encoding,
// coin-count width and lane indices.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP,
    HOLD
  } state_t;

  localparam int COIN_CNT_W = 3;

  localparam logic LANE_0 = 1'b0;
  localparam logic LANE_1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin picker: on a tie the lane not served last wins.
// Purely combinational; the caller only consults it while idle.
module rr_arb2
  import vend_pkg::*;
(
  input  logic req_0,
  input  logic req_1,
  input  logic last_served,
  output logic pick_0,
  output logic pick_1
);

  assign pick_0 = req_0 & (~req_1 | (last_served == LANE_1));
  assign pick_1 = req_1 & (~req_0 | (last_served == LANE_0));

endmodule

// File: rtl/change_hopper_arbiter.sv
// Shares one change-coin hopper between two vending lanes, issuing spaced coin pulses.
// Optional stock tracking and short-payout detection under `HOPPER_LEVEL_EN.
module change_hopper_arbiter
  import vend_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int LEVEL_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_0,
  input  logic                  req_1,
  input  logic [COIN_CNT_W-1:0] cnt_0,
  input  logic [COIN_CNT_W-1:0] cnt_1,
  input  logic                  hopper_ready,
  output logic                  grant_0,
  output logic                  grant_1,
  output logic                  coin_out,
  output logic                  done_0,
  output logic                  done_1,
`ifdef HOPPER_LEVEL_EN
  input  logic                  refill_load,
  input  logic [LEVEL_W-1:0]    refill_value,
  output logic                  short_out,
  output logic                  hopper_empty,
`endif
  output logic                  busy
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  state_t                  state, state_n;
  logic [COIN_CNT_W-1:0]   remaining, rem_n;
  logic [GAP_W-1:0]        gap_cnt, gap_n;
  logic                    lane, lane_n;
  logic                    last_served, last_n;
  logic                    grant0_n, grant1_n, coin_n, done0_n, done1_n, busy_n;
  logic                    pick_0, pick_1;
  logic                    served_req;
  logic                    stock_out;

`ifdef HOPPER_LEVEL_EN
  logic [LEVEL_W-1:0] stock, stock_n;
  logic               short_n;
  assign stock_out = (stock == '0);
`else
  logic [LEVEL_W-1:0] unused_level;
  assign unused_level = '0;
  assign stock_out    = 1'b0;
`endif

  rr_arb2 u_rr_arb2 (
    .req_0       (req_0),
    .req_1       (req_1),
    .last_served (last_served),
    .pick_0      (pick_0),
    .pick_1      (pick_1)
  );

  assign served_req = (lane == LANE_1) ? req_1 : req_0;

  always_comb begin
    state_n  = state;
    rem_n    = remaining;
    gap_n    = gap_cnt;
    lane_n   = lane;
    last_n   = last_served;
    grant0_n = grant_0;
    grant1_n = grant_1;
    coin_n   = 1'b0;
    done0_n  = 1'b0;
    done1_n  = 1'b0;
`ifdef HOPPER_LEVEL_EN
    short_n  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (pick_0 || pick_1) begin
          lane_n   = pick_1;
          rem_n    = pick_1 ? cnt_1 : cnt_0;
          grant0_n = pick_0;
          grant1_n = pick_1;
          state_n  = PULSE;
        end
      end
      PULSE: begin
        // An empty hopper ends the payout early; leftover coins are dropped.
        if (remaining == '0 || stock_out) begin
          grant0_n = 1'b0;
          grant1_n = 1'b0;
          done0_n  = (lane == LANE_0);
          done1_n  = (lane == LANE_1);
`ifdef HOPPER_LEVEL_EN
          short_n  = (remaining != '0);
`endif
          last_n   = lane;
          state_n  = HOLD;
        end else if (hopper_ready) begin
          coin_n = 1'b1;
          rem_n  = remaining - COIN_CNT_W'(1);
          if (GAP_CYCLES > 0) begin
            gap_n   = GAP_LOAD;
            state_n = GAP;
          end
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_n = PULSE;
        else               gap_n   = gap_cnt - GAP_W'(1);
      end
      HOLD: begin
        if (!served_req) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      remaining   <= '0;
      gap_cnt     <= '0;
      lane        <= LANE_0;
      last_served <= LANE_1;
      grant_0     <= 1'b0;
      grant_1     <= 1'b0;
      coin_out    <= 1'b0;
      done_0      <= 1'b0;
      done_1      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      remaining   <= rem_n;
      gap_cnt     <= gap_n;
      lane        <= lane_n;
      last_served <= last_n;
      grant_0     <= grant0_n;
      grant_1     <= grant1_n;
      coin_out    <= coin_n;
      done_0      <= done0_n;
      done_1      <= done1_n;
      busy        <= busy_n;
    end
  end

`ifdef HOPPER_LEVEL_EN
  // A refill in the same cycle as a coin wins over the decrement.
  always_comb begin
    stock_n = stock;
    if (refill_load)  stock_n = refill_value;
    else if (coin_n)  stock_n = stock - LEVEL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stock        <= '0;
      hopper_empty <= 1'b1;
      short_out    <= 1'b0;
    end else begin
      stock        <= stock_n;
      hopper_empty <= (stock_n == '0);
      short_out    <= short_n;
    end
  end
`endif

endmodule

// File: tb/tb_change_hopper_arbiter.sv
// Scoreboard bench for change_hopper_arbiter: directed payouts push expected
// coin/done events with their cycle numbers; a monitor pops and compares them.
module tb_change_hopper_arbiter;

  localparam int EV_COIN = 0;
  localparam int EV_D0   = 1;
  localparam int EV_D1   = 2;

  typedef struct {
    int cyc;
    int kind;
    bit sh;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_0, req_1;
  logic [2:0] cnt_0, cnt_1;
  logic       hopper_ready;
  logic       grant_0, grant_1, coin_out, done_0, done_1, busy;
`ifdef HOPPER_LEVEL_EN
  logic       refill_load;
  logic [7:0] refill_value;
  logic       short_out, hopper_empty;
`endif

  int  cyc = 0;
  int  n_checks = 0;
  int  n_pass = 0;
  ev_t sb[$];

  change_hopper_arbiter #(.GAP_CYCLES(2), .LEVEL_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_0        (req_0),
    .req_1        (req_1),
    .cnt_0        (cnt_0),
    .cnt_1        (cnt_1),
    .hopper_ready (hopper_ready),
    .grant_0      (grant_0),
    .grant_1      (grant_1),
    .coin_out     (coin_out),
    .done_0       (done_0),
    .done_1       (done_1),
`ifdef HOPPER_LEVEL_EN
    .refill_load  (refill_load),
    .refill_value (refill_value),
    .short_out    (short_out),
    .hopper_empty (hopper_empty),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic expect_ev(input int kind, input int c, input bit sh = 1'b0);
    ev_t e;
    e.cyc  = c;
    e.kind = kind;
    e.sh   = sh;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int lane, output int d);
    d = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if ((lane == 0 && done_0) || (lane == 1 && done_1)) begin
        d = cyc;
        break;
      end
    end
    if (d < 0) begin
      n_checks++;
      $display("FAIL done_%0d timeout: got no pulse, expected one within 80 cycles", lane);
      d = cyc;
    end
  endtask

`ifdef HOPPER_LEVEL_EN
  task automatic refill(input int v);
    refill_load  = 1'b1;
    refill_value = 8'(v);
    @(negedge clk);
    refill_load  = 1'b0;
  endtask
`endif

  // Monitor: every coin or done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    int  kind;
    ev_t e;
    if (coin_out || done_0 || done_1) begin
      kind = coin_out ? EV_COIN : (done_0 ? EV_D0 : EV_D1);
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected event: got kind %0d at cycle %0d, expected none", kind, cyc);
      end else begin
        e = sb.pop_front();
        check("event kind", kind, e.kind);
        check("event cycle", cyc, e.cyc);
`ifdef HOPPER_LEVEL_EN
        if (kind != EV_COIN) check("short_out", int'(short_out), int'(e.sh));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, d;
    reset = 1'b1; req_0 = 1'b0; req_1 = 1'b0; cnt_0 = '0; cnt_1 = '0; hopper_ready = 1'b1;
`ifdef HOPPER_LEVEL_EN
    refill_load = 1'b0; refill_value = '0;
`endif
    repeat (3) @(negedge clk);
    check("reset grant_0", int'(grant_0), 0);
    check("reset grant_1", int'(grant_1), 0);
    check("reset coin_out", int'(coin_out), 0);
    check("reset done_0", int'(done_0), 0);
    check("reset done_1", int'(done_1), 0);
    check("reset busy", int'(busy), 0);
`ifdef HOPPER_LEVEL_EN
    check("reset hopper_empty", int'(hopper_empty), 1);
`endif
    reset = 1'b0;
`ifdef HOPPER_LEVEL_EN
    refill(200);
`endif
    @(negedge clk);

    // First tie after reset goes to lane 0; lane 1 is served after req_0 drops.
    base = cyc; req_0 = 1'b1; req_1 = 1'b1; cnt_0 = 3'd1; cnt_1 = 3'd1;
    expect_ev(EV_COIN, base + 2); expect_ev(EV_D0, base + 5);
    @(negedge clk);
    check("tie1 grant_0", int'(grant_0), 1);
    check("tie1 grant_1", int'(grant_1), 0);
    check("tie1 busy", int'(busy), 1);
    wait_done(0, d); req_0 = 1'b0;
    expect_ev(EV_COIN, d + 3); expect_ev(EV_D1, d + 6);
    wait_done(1, d); req_1 = 1'b0;
    @(negedge clk);

    // Second tie: lane 1 was served last, so lane 0 wins again.
    base = cyc; req_0 = 1'b1; req_1 = 1'b1;
    expect_ev(EV_COIN, base + 2); expect_ev(EV_D0, base + 5);
    @(negedge clk);
    check("tie2 grant_0", int'(grant_0), 1);
    check("tie2 grant_1", int'(grant_1), 0);
    wait_done(0, d); req_0 = 1'b0;
    expect_ev(EV_COIN, d + 3); expect_ev(EV_D1, d + 6);
    wait_done(1, d); req_1 = 1'b0;
    @(negedge clk);

    // Zero-coin request: done in cycle 2, no pulse.
    base = cyc; req_1 = 1'b1; cnt_1 = 3'd0;
    expect_ev(EV_D1, base + 2);
    @(negedge clk);
    check("cnt0 grant_1", int'(grant_1), 1);
    wait_done(1, d); req_1 = 1'b0;
    @(negedge clk);

    // Lane 0, three coins: grant cycles 1..10, coins 2/5/8, done 11, idle at 12.
    base = cyc; req_0 = 1'b1; cnt_0 = 3'd3;
    expect_ev(EV_COIN, base + 2); expect_ev(EV_COIN, base + 5);
    expect_ev(EV_COIN, base + 8); expect_ev(EV_D0, base + 11);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      check($sformatf("cnt3 grant_0 c%0d", n), int'(grant_0), (n <= 10) ? 1 : 0);
      if (n >= 11) check($sformatf("cnt3 busy c%0d", n), int'(busy), (n == 11) ? 1 : 0);
      if (n == 11) req_0 = 1'b0;
    end

    // hopper_ready low for four PULSE samples delays the second coin and done by 4.
    base = cyc; req_0 = 1'b1; cnt_0 = 3'd2;
    expect_ev(EV_COIN, base + 2); expect_ev(EV_COIN, base + 9); expect_ev(EV_D0, base + 12);
    repeat (4) @(negedge clk);
    hopper_ready = 1'b0;
    repeat (4) @(negedge clk);
    hopper_ready = 1'b1;
    wait_done(0, d);
    check("stall done latency", d - base, 12);
    req_0 = 1'b0;
    @(negedge clk);

    // Reset right after the first coin of a five-coin payout abandons it.
    base = cyc; req_0 = 1'b1; cnt_0 = 3'd5;
    expect_ev(EV_COIN, base + 2);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst grant_0", int'(grant_0), 0);
    check("midrst busy", int'(busy), 0);
    check("midrst coin_out", int'(coin_out), 0);
    check("midrst done_0", int'(done_0), 0);
    reset = 1'b0; req_0 = 1'b0;
`ifdef HOPPER_LEVEL_EN
    refill(200);
`endif
    @(negedge clk);
    base = cyc; req_1 = 1'b1; cnt_1 = 3'd1;
    expect_ev(EV_COIN, base + 2); expect_ev(EV_D1, base + 5);
    @(negedge clk);
    check("post-reset grant_1", int'(grant_1), 1);
    check("post-reset grant_0", int'(grant_0), 0);
    wait_done(1, d); req_1 = 1'b0;
    @(negedge clk);

`ifdef HOPPER_LEVEL_EN
    // Stock of 2 against a request for 4: two coins, then a short done.
    refill(2);
    base = cyc; req_0 = 1'b1; cnt_0 = 3'd4;
    expect_ev(EV_COIN, base + 2); expect_ev(EV_COIN, base + 5); expect_ev(EV_D0, base + 8, 1'b1);
    wait_done(0, d);
    check("short hopper_empty", int'(hopper_empty), 1);
    req_0 = 1'b0;
    @(negedge clk);
`endif

    repeat (5) @(negedge clk);
    check("scoreboard drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
